// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor for two CPUs (A, B) sharing a memory switch-board.
// A common prescaler produces a timeout tick. Each CPU has its own
// timeout timer, recovery counter, OK/FAIL/RECOVER state machine and
// saturating failure counter.
module heartbeat_monitor #(
  parameter int unsigned PRESCALE      = 100,
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned RECOVER_CNT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A_hb,
  input  logic       B_hb,
  output logic       CPUA_fail,
  output logic       CPUB_fail,
  output logic       fail_change,
  output logic [7:0] A_fail_cnt,
  output logic [7:0] B_fail_cnt
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned RCV_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NCH   = 2;

  localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(PRESCALE - 1);
  localparam logic [TMR_W-1:0] TMO_SAT  = TMR_W'(TIMEOUT_TICKS);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [RCV_W-1:0] RCV_LAST = RCV_W'(RECOVER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               RCV_ONE  = (RECOVER_CNT == 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAIL    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  logic [TMR_W-1:0] r_presc;
  state_t           r_state [NCH];
  logic [TMR_W-1:0] r_timer [NCH];
  logic [RCV_W-1:0] r_rcv   [NCH];
  logic [CNT_W-1:0] r_fcnt  [NCH];
  logic [NCH-1:0]   r_fail;
  logic             r_fail_change;

  logic             w_tick;
  logic [NCH-1:0]   w_hb;
  logic [NCH-1:0]   w_timeout;
  logic [NCH-1:0]   w_set;
  logic [NCH-1:0]   w_clr;

  assign w_tick = (r_presc == PRE_LAST);
  assign w_hb   = {B_hb, A_hb};

  // Per-channel timeout event and fail-flag set/clear decode.
  always_comb begin
    w_timeout = '0;
    w_set     = '0;
    w_clr     = '0;
    for (int i = 0; i < NCH; i++) begin
      w_timeout[i] = w_tick & ~w_hb[i] & (r_timer[i] == TMO_LAST);
      w_set[i]     = (r_state[i] == ST_OK) & w_timeout[i];
      w_clr[i]     = w_hb[i] & (((r_state[i] == ST_FAIL) & RCV_ONE) |
                                ((r_state[i] == ST_RECOVER) & (r_rcv[i] == RCV_LAST)));
    end
  end

  // Free-running prescaler, wraps after PRESCALE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + TMR_W'(1);
    end
  end

  // Channel timers, state machines, fail flags and failure counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_OK;
        r_timer[i] <= '0;
        r_rcv[i]   <= '0;
        r_fcnt[i]  <= '0;
      end
      r_fail        <= '0;
      r_fail_change <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // Heartbeat wins over a coincident tick.
        if (w_hb[i]) begin
          r_timer[i] <= '0;
        end else if (w_tick && (r_timer[i] != TMO_SAT)) begin
          r_timer[i] <= r_timer[i] + TMR_W'(1);
        end

        case (r_state[i])
          ST_OK: begin
            if (w_timeout[i]) begin
              r_state[i] <= ST_FAIL;
              r_rcv[i]   <= '0;
              if (r_fcnt[i] != CNT_MAX) begin
                r_fcnt[i] <= r_fcnt[i] + CNT_W'(1);
              end
            end
          end
          ST_FAIL: begin
            if (w_hb[i]) begin
              if (RCV_ONE) begin
                r_state[i] <= ST_OK;
                r_rcv[i]   <= '0;
              end else begin
                r_state[i] <= ST_RECOVER;
                r_rcv[i]   <= RCV_W'(1);
              end
            end
          end
          ST_RECOVER: begin
            if (w_hb[i]) begin
              if (r_rcv[i] == RCV_LAST) begin
                r_state[i] <= ST_OK;
                r_rcv[i]   <= '0;
              end else begin
                r_rcv[i] <= r_rcv[i] + RCV_W'(1);
              end
            end else if (w_timeout[i]) begin
              // Relapse: no failure-count increment.
              r_state[i] <= ST_FAIL;
              r_rcv[i]   <= '0;
            end
          end
          default: begin
            r_state[i] <= ST_OK;
            r_rcv[i]   <= '0;
          end
        endcase
      end
      r_fail        <= (r_fail | w_set) & ~w_clr;
      r_fail_change <= |(w_set | w_clr);
    end
  end

  assign CPUA_fail   = r_fail[0];
  assign CPUB_fail   = r_fail[1];
  assign fail_change = r_fail_change;
  assign A_fail_cnt  = r_fcnt[0];
  assign B_fail_cnt  = r_fcnt[1];

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with PRESCALE=4, TIMEOUT_TICKS=5,
// RECOVER_CNT=3. Table rows hold inputs for a run of cycles and the
// outputs expected after every cycle of that run.
module tb_heartbeat_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       A_hb;
  logic       B_hb;
  logic       CPUA_fail;
  logic       CPUB_fail;
  logic       fail_change;
  logic [7:0] A_fail_cnt;
  logic [7:0] B_fail_cnt;

  int checks   = 0;
  int failures = 0;

  heartbeat_monitor #(
    .PRESCALE     (4),
    .TIMEOUT_TICKS(5),
    .RECOVER_CNT  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A_hb       (A_hb),
    .B_hb       (B_hb),
    .CPUA_fail  (CPUA_fail),
    .CPUB_fail  (CPUB_fail),
    .fail_change(fail_change),
    .A_fail_cnt (A_fail_cnt),
    .B_fail_cnt (B_fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        a;
    logic        b;
    int unsigned cyc;
    logic        ea;
    logic        eb;
    logic        ec;
    logic [7:0]  eacnt;
    logic [7:0]  ebcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic a, logic b, int unsigned cyc,
                              logic ea, logic eb, logic ec,
                              logic [7:0] eacnt, logic [7:0] ebcnt);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.cyc = cyc;
    v.ea = ea; v.eb = eb; v.ec = ec; v.eacnt = eacnt; v.ebcnt = ebcnt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string name, int idx, logic ea, logic eb, logic ec,
                           logic [7:0] eacnt, logic [7:0] ebcnt);
    logic [18:0] act;
    logic [18:0] exp;
    act = {CPUA_fail, CPUB_fail, fail_change, A_fail_cnt, B_fail_cnt};
    exp = {ea, eb, ec, eacnt, ebcnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got A=%b B=%b chg=%b acnt=%0d bcnt=%0d, want A=%b B=%b chg=%b acnt=%0d bcnt=%0d",
               name, idx, act[18], act[17], act[16], act[15:8], act[7:0],
               ea, eb, ec, eacnt, ebcnt);
    end
  endtask

  task automatic check1(string name, int idx, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic check8(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    A_hb = 1'b0;
    B_hb = 1'b0;

    // Edge numbers below count clock edges since reset release; ticks land on multiples of 4.
    vecs.push_back(mk(1, 0, 0,  2, 0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 0, 19, 0, 0, 0, 0, 0)); // edges 1..19 quiet
    vecs.push_back(mk(0, 0, 0,  1, 1, 1, 1, 1, 1)); // edge 20: both fail, one pulse
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 1, 1)); // edge 21: A hb -> RECOVER 1
    vecs.push_back(mk(0, 0, 0,  7, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 1, 1)); // edge 29: RECOVER 2
    vecs.push_back(mk(0, 0, 0,  7, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 1, 1, 1)); // edge 37: A back to OK
    vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 17, 0, 1, 0, 1, 1)); // edges 39..55, A timer reaches 4
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 1, 1)); // edge 56: hb on would-be timeout tick
    vecs.push_back(mk(0, 0, 0, 19, 0, 1, 0, 1, 1)); // edges 57..75
    vecs.push_back(mk(0, 0, 0,  1, 1, 1, 1, 2, 1)); // edge 76: A fails again
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 2, 1)); // edge 77: RECOVER 1
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 2, 1)); // edge 78: RECOVER 2
    vecs.push_back(mk(0, 0, 0, 18, 1, 1, 0, 2, 1)); // edge 96: relapse to FAIL silently
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 2, 1)); // needs three hb again
    vecs.push_back(mk(0, 1, 0,  1, 1, 1, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 1, 2, 1)); // edge 99: A OK
    vecs.push_back(mk(1, 1, 1,  1, 0, 0, 0, 0, 0)); // reset with B in FAIL, hb ignored
    vecs.push_back(mk(0, 0, 0, 15, 0, 0, 0, 0, 0)); // A fed every 16 cycles
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 0)); // edge 16
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 0, 1, 1, 0, 1)); // edge 20: only B fails
    vecs.push_back(mk(0, 0, 0, 11, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0, 1)); // edge 32
    vecs.push_back(mk(0, 0, 0, 15, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0, 1)); // edge 48
    vecs.push_back(mk(0, 0, 0, 15, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0, 1)); // edge 64

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      A_hb = vecs[i].a;
      B_hb = vecs[i].b;
      for (int c = 0; c < int'(vecs[i].cyc); c++) begin
        step();
        check_all("vec", i, vecs[i].ea, vecs[i].eb, vecs[i].ec,
                  vecs[i].eacnt, vecs[i].ebcnt);
      end
    end
    A_hb = 1'b0;
    B_hb = 1'b0;

    // B driven through 300 OK->FAIL cycles; the counter must stick at 255.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bit risen;
      int nhb;
      risen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        step();
        if (CPUB_fail) begin
          risen = 1'b1;
          break;
        end
      end
      check1("b_rise", i, risen, 1'b1);
      if (!risen) break;
      check1("b_rise_chg", i, fail_change, 1'b1);
      check8("b_cnt", i, B_fail_cnt, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      nhb = (i == 299) ? 2 : 3;
      for (int h = 0; h < nhb; h++) begin
        B_hb = 1'b1;
        step();
        B_hb = 1'b0;
      end
      if (i < 299) check1("b_recovered", i, CPUB_fail, 1'b0);
    end

    // B now mid-RECOVER at count 2; A failed once and never recovered.
    check1("b_in_recover", 0, CPUB_fail, 1'b1);
    check8("a_cnt_indep", 0, A_fail_cnt, 8'd1);
    check8("b_cnt_sat", 0, B_fail_cnt, 8'd255);
    rst = 1'b1;
    step();
    check_all("rst_mid_recover", 0, 0, 0, 0, 8'd0, 8'd0);
    rst = 1'b0;
    step();
    check_all("after_rst", 0, 0, 0, 0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/heartbeat_monitor.md
HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

Interface
REQ-001 SHALL have parameter PRESCALE, default 100, clk cycles per timeout tick (legal range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 1000, ticks without heartbeat before a CPU is declared failed (legal range 1..65535).
REQ-003 SHALL have parameter RECOVER_CNT, default 3, consecutive in-time heartbeats a failed CPU needs to be declared healthy again (legal range 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock of the block.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port A_hb, input, 1, one-cycle pulse when CPU A writes its heartbeat word.
REQ-007 SHALL have port B_hb, input, 1, one-cycle pulse when CPU B writes its heartbeat word.
REQ-008 SHALL have port CPUA_fail, output, 1, CPU A declared failed; feeds the shared-memory switch-board status.
REQ-009 SHALL have port CPUB_fail, output, 1, CPU B declared failed.
REQ-010 SHALL have port fail_change, output, 1, one-cycle pulse when either fail output changes value.
REQ-011 SHALL have port A_fail_cnt, output, 8, saturating count of CPU A OK->FAIL transitions.
REQ-012 SHALL have port B_fail_cnt, output, 8, saturating count of CPU B OK->FAIL transitions.

Function
REQ-013 SHALL implement a prescaler counting 0..PRESCALE-1 and wrapping, asserting tick for one cycle when the count equals PRESCALE-1.
REQ-014 SHALL keep one independent channel per CPU (A, B), each with a 16-bit timer, an 8-bit recovery counter and a state machine with states OK, FAIL and RECOVER.
REQ-015 SHALL clear the channel timer to 0 on a heartbeat pulse; otherwise it SHALL increment on tick and saturate at TIMEOUT_TICKS.
REQ-016 Timeout event SHALL be defined as: tick=1, no heartbeat in the same cycle, and timer = TIMEOUT_TICKS-1.
REQ-017 In OK, a timeout event SHALL move the channel to FAIL.
REQ-018 In FAIL, a heartbeat SHALL move the channel to RECOVER with recovery counter 1, or directly to OK if RECOVER_CNT=1.
REQ-019 In RECOVER, each heartbeat SHALL increment the recovery counter, and the channel SHALL enter OK on the heartbeat that brings the counter to RECOVER_CNT.
REQ-020 In RECOVER, a timeout event SHALL return the channel to FAIL with the recovery counter cleared to 0.
REQ-021 When a heartbeat and a tick coincide, the heartbeat SHALL take precedence: the timer is cleared and no timeout occurs.
REQ-022 CPUx_fail SHALL be a registered output equal to 1 whenever the channel state is FAIL or RECOVER, and SHALL change in the cycle after the causing event.
REQ-023 fail_change SHALL be a registered pulse asserted in the same cycle that CPUA_fail or CPUB_fail changes; simultaneous changes on both SHALL produce a single pulse.
REQ-024 A_fail_cnt and B_fail_cnt SHALL increment on each OK->FAIL transition and hold at 255; RECOVER->FAIL SHALL NOT increment them.
REQ-025 The channels SHALL be fully independent; the state of one SHALL never affect the other.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL clear the prescaler, both timers, both recovery counters and both fail counters to 0, and place both channels in OK.
REQ-027 Under reset, CPUA_fail, CPUB_fail and fail_change SHALL be 0.
REQ-028 Reset asserted mid-FAIL or mid-RECOVER SHALL abort that state with no fail_change pulse on the following cycle.
REQ-029 Heartbeat pulses during rst=1 SHALL be ignored.

Verification (PRESCALE=4, TIMEOUT_TICKS=5, RECOVER_CNT=3)
REQ-030 Release reset with no heartbeats on either CPU -> CPUA_fail and CPUB_fail both rise 20 cycles after reset release, with one fail_change pulse and A_fail_cnt = B_fail_cnt = 1.
REQ-031 Pulse A_hb every 16 cycles -> CPUA_fail stays 0 indefinitely while CPUB_fail still rises on schedule.
REQ-032 With A in FAIL, send 3 A_hb pulses 8 cycles apart -> CPUA_fail falls the cycle after the 3rd pulse with a fail_change pulse, and A_fail_cnt is unchanged.
REQ-033 With A in RECOVER at count 2, stop heartbeats -> CPUA_fail stays 1, the state returns to FAIL and A_fail_cnt is not incremented.
REQ-034 Hold A_hb on exactly the tick cycle that would time out -> no failure, and the timer restarts from 0.
REQ-035 Force 300 OK->FAIL cycles on B -> B_fail_cnt saturates at 255; asserting rst mid-RECOVER then yields all outputs 0 the next cycle.
